// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one WIDTH-bit add/shift per clock,
// operands in and product out over valid/ready handshakes.
module shift_add_mult #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;

    // Adder stage with carry-out kept so the full-scale product stays exact.
    always_comb begin
        w_addend = '0;
        if (r_q[0]) begin
            w_addend = r_m;
        end
        w_sum = {1'b0, r_acc} + {1'b0, w_addend};
    end

    // Handshake flags are registered alongside the state they decode.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_m         <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_m        <= i_a;
                        r_q        <= i_b;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_sum[WIDTH:1];
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_product   = {r_acc, r_q};

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed-vector bench for shift_add_mult at WIDTH=4.
module tb_shift_add_mult;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int errors;
    int checks;
    int cyc;

    shift_add_mult #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_product   (product),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got in_ready/out_valid/busy=%b expected 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (product !== 8'h00) begin
            errors++;
            $display("FAIL reset_product: got %h expected 00", product);
        end
    endtask

    // Single transaction with out_ready high; checks latency, busy span, product, return to IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [2*W-1:0] exp, input string name);
        int n;
        int busy_n;
        out_ready = 1'b1;
        a = ta; b = tb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 4'hA; b = 4'h5;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_in_ready_drop: got %b expected 0", name, in_ready);
        end
        n = 0; busy_n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_n++;
            tick();
            n++;
        end
        checks++;
        if (n != 4 || busy_n != 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d clocks busy %0d expected 4 and 4", name, n, busy_n);
        end
        checks++;
        if (product !== exp) begin
            errors++;
            $display("FAIL %s_product: got %h expected %h", name, product, exp);
        end
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL %s_back_idle: got %b expected 100", name, {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_basic();
        run_op(4'd3, 4'd5, 8'h0F, "mul_3x5");
    endtask

    task automatic test_max();
        run_op(4'd15, 4'd15, 8'hE1, "mul_15x15");
    endtask

    task automatic test_zero();
        run_op(4'd0, 4'd9, 8'h00, "mul_0x9");
        run_op(4'd9, 4'd0, 8'h00, "mul_9x0");
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        a = 4'd7; b = 4'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_latency: got %0d clocks expected 4", n);
        end
        in_valid = 1'b1; a = 4'd1; b = 4'd1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (product !== 8'h2A || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got product=%h out_valid=%b in_ready=%b expected 2a 1 0",
                         i, product, out_valid, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        run_op(4'd1, 4'd1, 8'h01, "bp_next_1x1");
    endtask

    task automatic test_reset_mid_run();
        int seen;
        out_ready = 1'b1;
        a = 4'd12; b = 4'd11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100 || product !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: got flags=%b product=%h expected 100 00",
                     {in_ready, busy, out_valid}, product);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrun_no_result: got %0d out_valid cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   va [3];
        logic [W-1:0]   vb [3];
        logic [2*W-1:0] vp [3];
        int acc_t [3];
        int n;
        va[0] = 4'd2;  vb[0] = 4'd3;  vp[0] = 8'd6;
        va[1] = 4'd9;  vb[1] = 4'd13; vp[1] = 8'd117;
        va[2] = 4'd15; vb[2] = 4'd1;  vp[2] = 8'd15;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = va[k]; b = vb[k];
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            tick();
            acc_t[k] = cyc;
            if (k == 2) in_valid = 1'b0;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (product !== vp[k] || n != 4) begin
                errors++;
                $display("FAIL b2b_product_%0d: got %h after %0d clocks expected %h after 4",
                         k, product, n, vp[k]);
            end
            tick();
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (acc_t[k] - acc_t[k-1] != 6) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected 6", k, acc_t[k] - acc_t[k-1]);
            end
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_idle: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
